// File: rtl/crc_pkg.sv
// Shared CRC helpers: XOR-matrix generators for the parallel byte advance,
// bit reflection, and the packet FSM state type.
package crc_pkg;

   localparam int MAX_BITS = 512;
   localparam int DCW      = $clog2(MAX_BITS);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} crc_fsm_e;
   typedef logic [63:0][63:0]         crc_scols_t;
   typedef logic [MAX_BITS-1:0][63:0] crc_dcols_t;

   function automatic logic [63:0] crc_mask(input int width);
      return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
   endfunction

   // Serial MSB-first register advanced over nbits zero input bits.
   function automatic logic [63:0] crc_zero_adv(input int width, input logic [63:0] poly,
                                                input logic [63:0] s, input int nbits);
      logic [63:0] r;
      logic        fb;
      r = s;
      for (int i = 0; i < nbits; i++) begin
         fb = r[6'(width - 1)];
         r  = (r << 1) & crc_mask(width);
         if (fb) r = r ^ (poly & crc_mask(width));
      end
      return r;
   endfunction

   // Column j: contribution of state bit j after nbits input bits.
   function automatic crc_scols_t crc_state_cols(input int width, input logic [63:0] poly,
                                                 input int nbits);
      crc_scols_t cols;
      for (int j = 0; j < 64; j++) begin
         cols[6'(j)] = (j < width) ? crc_zero_adv(width, poly, 64'd1 << j, nbits) : 64'd0;
      end
      return cols;
   endfunction

   // Column t: contribution of stream bit t (t = 0 first on the wire).
   function automatic crc_dcols_t crc_data_cols(input int width, input logic [63:0] poly,
                                                input int nbits);
      crc_dcols_t  cols;
      logic [63:0] c;
      cols = '0;
      c    = poly & crc_mask(width);
      for (int t = nbits - 1; t >= 0; t--) begin
         cols[DCW'(t)] = c;
         c = crc_zero_adv(width, poly, c, 1);
      end
      return cols;
   endfunction

   function automatic logic [63:0] crc_reflect(input logic [63:0] v, input int width);
      logic [63:0] r;
      r = 64'd0;
      for (int i = 0; i < 64; i++) begin
         if (i < width) r[6'(width - 1 - i)] = v[6'(i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/stream_crc_if.sv
// Packet input stream and CRC result stream of stream_crc.
interface stream_crc_if #(
   parameter int DWIDTH    = 512,
   parameter int CRC_WIDTH = 32
);
   logic [DWIDTH-1:0]    s_axis_tdata;
   logic [DWIDTH/8-1:0]  s_axis_tkeep;
   logic                 s_axis_tlast;
   logic                 s_axis_tvalid;
   logic                 s_axis_tready;
   logic [CRC_WIDTH-1:0] crc_tdata;
   logic                 crc_tuser;
   logic                 crc_tvalid;
   logic                 crc_tready;

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, crc_tready,
      input  s_axis_tready, crc_tdata, crc_tuser, crc_tvalid
   );

   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, crc_tready,
      output s_axis_tready, crc_tdata, crc_tuser, crc_tvalid
   );
endinterface

// File: rtl/crc_byte_adv.sv
// Combinational CRC advance over NBYTES bytes using elaboration-time XOR matrices.
module crc_byte_adv
   import crc_pkg::*;
#(
   parameter int          CRC_WIDTH = 32,
   parameter logic [63:0] CRC_POLY  = 64'h0000_0000_04C1_1DB7,
   parameter bit          REFIN     = 1'b1,
   parameter int          NBYTES    = 1
) (
   input  logic [CRC_WIDTH-1:0] state,
   input  logic [NBYTES*8-1:0]  data,
   output logic [CRC_WIDTH-1:0] next
);
   localparam int         NBITS = NBYTES * 8;
   localparam crc_scols_t SCOLS = crc_state_cols(CRC_WIDTH, CRC_POLY, NBITS);
   localparam crc_dcols_t DCOLS = crc_data_cols(CRC_WIDTH, CRC_POLY, NBITS);

   logic [NBITS-1:0]     dbits_s;
   logic [CRC_WIDTH-1:0] acc_s;

   // Wire order: reflected input feeds bit 0 of each byte first.
   for (genvar t = 0; t < NBITS; t++) begin : g_order
      assign dbits_s[t] = REFIN ? data[t] : data[(t / 8) * 8 + 7 - (t % 8)];
   end

   // XOR together the matrix columns selected by state and data bits.
   always_comb begin
      acc_s = '0;
      for (int j = 0; j < CRC_WIDTH; j++) begin
         if (state[j]) acc_s = acc_s ^ SCOLS[j][CRC_WIDTH-1:0];
         else          acc_s = acc_s;
      end
      for (int t = 0; t < NBITS; t++) begin
         if (dbits_s[t]) acc_s = acc_s ^ DCOLS[t][CRC_WIDTH-1:0];
         else            acc_s = acc_s;
      end
   end

   assign next = acc_s;
endmodule

// File: rtl/stream_crc.sv
// Per-packet CRC over an AXI-Stream input with a registered, back-pressured
// result stream; one full beat or a partial last beat is absorbed per cycle.
module stream_crc
   import crc_pkg::*;
#(
   parameter int                   DWIDTH    = 512,
   parameter int                   CRC_WIDTH = 32,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 32'h04C11DB7,
   parameter logic [CRC_WIDTH-1:0] INIT      = 32'hFFFFFFFF,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 32'hFFFFFFFF,
   parameter bit                   REFIN     = 1'b1,
   parameter bit                   REFOUT    = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   stream_crc_if.slave bus
);
   localparam int NBY = DWIDTH / 8;
   localparam int NW  = $clog2(NBY + 1);

   crc_fsm_e             fsm_r, fsm_nxt_s;
   logic                 start_s, ready_s, accept_s, run_s, contig_s, full_s;
   logic [NW-1:0]        nkeep_s;
   logic [CRC_WIDTH-1:0] state_r, base_s, sel_s, result_s, crc_tdata_r;
   logic                 crc_tuser_r, crc_tvalid_r, err_r;
   logic [CRC_WIDTH-1:0] adv_s [NBY+1];

   assign ready_s  = !(crc_tvalid_r && !bus.crc_tready);
   assign accept_s = bus.s_axis_tvalid && ready_s;
   assign base_s   = start_s ? INIT : state_r;
   assign full_s   = &bus.s_axis_tkeep;
   assign contig_s = (bus.s_axis_tkeep >> nkeep_s) == '0;

   assign adv_s[0] = base_s;
   for (genvar k = 1; k <= NBY; k++) begin : g_adv
      crc_byte_adv #(
         .CRC_WIDTH(CRC_WIDTH),
         .CRC_POLY (64'(CRC_POLY)),
         .REFIN    (REFIN),
         .NBYTES   (k)
      ) u_adv (
         .state(base_s),
         .data (bus.s_axis_tdata[8*k-1:0]),
         .next (adv_s[k])
      );
   end

   // Length of the run of ones in tkeep starting at byte 0.
   always_comb begin
      nkeep_s = '0;
      run_s   = 1'b1;
      for (int i = 0; i < NBY; i++) begin
         if (run_s && bus.s_axis_tkeep[i]) nkeep_s = nkeep_s + NW'(1);
         else                              run_s   = 1'b0;
      end
   end

   assign sel_s    = adv_s[nkeep_s];
   assign result_s = (REFOUT ? CRC_WIDTH'(crc_reflect(64'(sel_s), CRC_WIDTH)) : sel_s) ^ XOR_OUT;

   // Packet FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_r <= ST_IDLE;
      else        fsm_r <= fsm_nxt_s;
   end

   // Next-state logic; a packet starts from INIT whenever the FSM is idle.
   always_comb begin
      fsm_nxt_s = fsm_r;
      start_s   = 1'b0;
      case (fsm_r)
         ST_IDLE: begin
            start_s = 1'b1;
            if (accept_s && !bus.s_axis_tlast) fsm_nxt_s = ST_ACTIVE;
            else                               fsm_nxt_s = ST_IDLE;
         end
         ST_ACTIVE: begin
            if (accept_s && bus.s_axis_tlast) fsm_nxt_s = ST_IDLE;
            else                              fsm_nxt_s = ST_ACTIVE;
         end
         default: begin
            fsm_nxt_s = ST_IDLE;
            start_s   = 1'b1;
         end
      endcase
   end

   // Running CRC, error accumulator and the held result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= INIT;
         err_r        <= 1'b0;
         crc_tdata_r  <= '0;
         crc_tuser_r  <= 1'b0;
         crc_tvalid_r <= 1'b0;
      end else if (accept_s && bus.s_axis_tlast) begin
         state_r      <= INIT;
         err_r        <= 1'b0;
         crc_tdata_r  <= result_s;
         crc_tuser_r  <= err_r || !contig_s || (nkeep_s == '0);
         crc_tvalid_r <= 1'b1;
      end else begin
         if (accept_s) begin
            state_r <= adv_s[NBY];
            err_r   <= err_r || !full_s;
         end
         if (bus.crc_tready) crc_tvalid_r <= 1'b0;
      end
   end

   assign bus.s_axis_tready = ready_s;
   assign bus.crc_tdata     = crc_tdata_r;
   assign bus.crc_tuser     = crc_tuser_r;
   assign bus.crc_tvalid    = crc_tvalid_r;
endmodule

// File: tb/tb_stream_crc.sv
// Directed and randomised checks of stream_crc against a bit-serial CRC model.
module tb_stream_crc;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stream_crc_if #(.DWIDTH(64), .CRC_WIDTH(32)) a_if ();
   stream_crc_if #(.DWIDTH(72), .CRC_WIDTH(16)) b_if ();

   stream_crc #(.DWIDTH(64)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));

   stream_crc #(
      .DWIDTH(72), .CRC_WIDTH(16), .CRC_POLY(16'h1021), .INIT(16'hFFFF),
      .XOR_OUT(16'h0000), .REFIN(1'b0), .REFOUT(1'b0)
   ) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

   int          checks = 0;
   int          errors = 0;
   int          n_in   = 0;
   int          n_out  = 0;
   bit          rnd_ready = 1'b0;
   logic [32:0] exp_q [$];
   logic [32:0] mon_e, e1, e2;
   logic [63:0] dq_v [$];
   logic [7:0]  kq_v [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_crc32(input logic [7:0] bq [$]);
      logic [31:0] s, r;
      logic        fb;
      s = 32'hFFFFFFFF;
      foreach (bq[i]) begin
         for (int b = 0; b < 8; b++) begin
            fb = s[31] ^ bq[i][b];
            s  = {s[30:0], 1'b0};
            if (fb) s = s ^ 32'h04C11DB7;
         end
      end
      for (int i = 0; i < 32; i++) r[i] = s[31-i];
      return r ^ 32'hFFFFFFFF;
   endfunction

   task automatic drive_a(input logic [63:0] d, input logic [7:0] k, input logic l);
      bit acc;
      int cyc;
      a_if.s_axis_tdata  = d;
      a_if.s_axis_tkeep  = k;
      a_if.s_axis_tlast  = l;
      a_if.s_axis_tvalid = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 200) begin
         @(negedge clk);
         acc = a_if.s_axis_tready;
         @(posedge clk);
         #1;
         cyc++;
      end
      a_if.s_axis_tvalid = 1'b0;
      check("a_beat_accepted", 64'(acc), 64'd1);
   endtask

   task automatic send_pkt(input logic [63:0] dq [$], input logic [7:0] kq [$], input bit gaps);
      logic [7:0] bq [$];
      bit         err;
      int         n;
      err = 1'b0;
      for (int i = 0; i < dq.size(); i++) begin
         if (i < dq.size() - 1) begin
            for (int j = 0; j < 8; j++) bq.push_back(dq[i][8*j +: 8]);
            if (kq[i] != 8'hFF) err = 1'b1;
         end else begin
            n = 0;
            while (n < 8 && kq[i][n]) n++;
            for (int j = 0; j < n; j++) bq.push_back(dq[i][8*j +: 8]);
            if (n == 0 || (kq[i] >> n) != 8'h00) err = 1'b1;
         end
      end
      exp_q.push_back({err, ref_crc32(bq)});
      n_in++;
      for (int i = 0; i < dq.size(); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         drive_a(dq[i], kq[i], i == dq.size() - 1);
      end
   endtask

   // Result scoreboard: every handshaken result is compared in order.
   always @(negedge clk) begin
      if (rst_n && a_if.crc_tvalid && a_if.crc_tready) begin
         n_out++;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("a_crc", 64'(a_if.crc_tdata), 64'(mon_e[31:0]));
            check("a_user", 64'(a_if.crc_tuser), 64'(mon_e[32]));
         end
      end
   end

   // Random result back-pressure.
   always @(posedge clk) begin
      #1;
      if (rnd_ready) a_if.crc_tready = 1'($urandom_range(0, 1));
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nb, n, cyc;
      rst_n = 1'b0;
      a_if.s_axis_tdata = '0; a_if.s_axis_tkeep = '0; a_if.s_axis_tlast = 1'b0;
      a_if.s_axis_tvalid = 1'b0; a_if.crc_tready = 1'b1;
      b_if.s_axis_tdata = '0; b_if.s_axis_tkeep = '0; b_if.s_axis_tlast = 1'b0;
      b_if.s_axis_tvalid = 1'b0; b_if.crc_tready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_tready", 64'(a_if.s_axis_tready), 64'd1);
      check("rst_tvalid", 64'(a_if.crc_tvalid), 64'd0);
      check("rst_tdata", 64'(a_if.crc_tdata), 64'd0);
      check("rst_tuser", 64'(a_if.crc_tuser), 64'd0);
      check("b_rst_tvalid", 64'(b_if.crc_tvalid), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("tready_after_rst", 64'(a_if.s_axis_tready), 64'd1);
      @(posedge clk); #1;

      // "123456789" over two beats
      dq_v = {64'h3837363534333231, 64'h0000000000000039}; kq_v = {8'hFF, 8'h01};
      send_pkt(dq_v, kq_v, 1'b0);
      check("check_latency_valid", 64'(a_if.crc_tvalid), 64'd1);
      check("check_value", 64'(a_if.crc_tdata), 64'hCBF43926);
      check("check_user", 64'(a_if.crc_tuser), 64'd0);

      dq_v = {64'h0000000000550031}; kq_v = {8'b0000_0101};
      send_pkt(dq_v, kq_v, 1'b0);
      check("noncontig_user", 64'(a_if.crc_tuser), 64'd1);

      dq_v = {64'h00000000DEADBEEF}; kq_v = {8'h00};
      send_pkt(dq_v, kq_v, 1'b0);
      check("zero_len_crc", 64'(a_if.crc_tdata), 64'h00000000);
      check("zero_len_user", 64'(a_if.crc_tuser), 64'd1);

      dq_v = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210}; kq_v = {8'h0F, 8'hFF};
      send_pkt(dq_v, kq_v, 1'b0);
      check("partial_nonlast_user", 64'(a_if.crc_tuser), 64'd1);

      dq_v = {64'h1122334455667788, 64'h99AABBCCDDEEFF00, 64'h0000000000C0FFEE};
      kq_v = {8'hFF, 8'hFF, 8'h07};
      send_pkt(dq_v, kq_v, 1'b0);
      check("clean_after_err_user", 64'(a_if.crc_tuser), 64'd0);

      // Result back-pressure with a second packet waiting
      repeat (2) begin @(posedge clk); #1; end
      a_if.crc_tready = 1'b0;
      dq_v = {64'h1111111111111111}; kq_v = {8'hFF};
      send_pkt(dq_v, kq_v, 1'b0);
      e1 = exp_q[exp_q.size() - 1];
      a_if.s_axis_tdata = 64'h2222222222222222; a_if.s_axis_tkeep = 8'hFF;
      a_if.s_axis_tlast = 1'b1; a_if.s_axis_tvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_tready", 64'(a_if.s_axis_tready), 64'd0);
         check("stall_hold_data", 64'(a_if.crc_tdata), 64'(e1[31:0]));
         @(posedge clk); #1;
      end
      a_if.crc_tready = 1'b1;
      dq_v = {64'h2222222222222222}; kq_v = {8'hFF};
      send_pkt(dq_v, kq_v, 1'b0);
      e2 = exp_q[exp_q.size() - 1];
      check("b2b_second_valid", 64'(a_if.crc_tvalid), 64'd1);
      check("b2b_second_data", 64'(a_if.crc_tdata), 64'(e2[31:0]));

      // Reset in the middle of a packet, then resend it whole
      repeat (3) begin @(posedge clk); #1; end
      drive_a(64'h3837363534333231, 8'hFF, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("midpkt_rst_tvalid", 64'(a_if.crc_tvalid), 64'd0);
      check("midpkt_rst_tready", 64'(a_if.s_axis_tready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      dq_v = {64'h3837363534333231, 64'h0000000000000039}; kq_v = {8'hFF, 8'h01};
      send_pkt(dq_v, kq_v, 1'b0);
      check("rst_resend_value", 64'(a_if.crc_tdata), 64'hCBF43926);

      // CRC-16/CCITT-FALSE, MSB-first, single 9-byte beat
      b_if.s_axis_tdata = 72'h393837363534333231; b_if.s_axis_tkeep = 9'h1FF;
      b_if.s_axis_tlast = 1'b1; b_if.s_axis_tvalid = 1'b1;
      @(negedge clk);
      check("b_tready", 64'(b_if.s_axis_tready), 64'd1);
      @(posedge clk); #1;
      b_if.s_axis_tvalid = 1'b0;
      check("b_valid", 64'(b_if.crc_tvalid), 64'd1);
      check("b_crc16", 64'(b_if.crc_tdata), 64'h29B1);
      check("b_user", 64'(b_if.crc_tuser), 64'd0);

      // Random lengths, keeps, gaps and back-pressure
      rnd_ready = 1'b1;
      for (int p = 0; p < 1000; p++) begin
         nb = $urandom_range(1, 4);
         dq_v = {}; kq_v = {};
         for (int i = 0; i < nb; i++) begin
            dq_v.push_back({$urandom, $urandom});
            if (i < nb - 1) begin
               kq_v.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF);
            end else if ($urandom_range(0, 9) == 0) begin
               kq_v.push_back(8'($urandom_range(0, 255)));
            end else begin
               n = $urandom_range(0, 8);
               kq_v.push_back(8'((16'd1 << n) - 16'd1));
            end
         end
         send_pkt(dq_v, kq_v, 1'b1);
      end
      rnd_ready = 1'b0;
      @(posedge clk); #2;
      a_if.crc_tready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      repeat (2) begin @(posedge clk); #1; end
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("count_in_out", 64'(n_out), 64'(n_in));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
